// File: rtl/grid_image_locator.sv
// rtl/grid_image_locator.sv - two-stage pixel-to-grid-cell locator with highlight overlay
//
// Maps a screen pixel (CounterX, CounterY) onto a GRID_COLS x GRID_ROWS grid of
// PIC_W x PIC_H product images. It produces the image ROM address, the cell
// index, an in-image flag and a highlight overlay colour.
//
// Ports:
//   CLK, RST               clock; synchronous active-high reset
//   CounterX, CounterY     screen pixel coordinates
//   HighlightedProductList bit k highlights cell k
//   SW2                    0: indicator strip on the image, 1: basket strip
//   ROM_Addr               image ROM address (0 when outside every image)
//   ImageID                cell index (0 when outside every image)
//   isImage                pixel lies inside an image
//   inHighlightedArea      pixel belongs to a highlight strip
//   PixelBus               HL_COLOR on highlight, white otherwise
//
// Every output is registered and lags CounterX/CounterY by exactly 2 cycles.
//
// Optional feature: define HIGHLIGHT_BLINK_EN to make the highlight blink.
// It toggles every BLINK_FRAMES frames and starts in the visible phase.
module grid_image_locator #(
  parameter int          CNTR_WIDTH_H       = 11,
  parameter int          CNTR_WIDTH_V       = 10,
  parameter int          ROM_ADDR_BUS_WIDTH = 17,
  parameter int          GRID_COLS          = 4,
  parameter int          GRID_ROWS          = 3,
  parameter int          PIC_W              = 100,
  parameter int          PIC_H              = 100,
  parameter int          X0                 = 308,
  parameter int          Y0                 = 20,
  parameter int          PITCH_X            = 128,
  parameter int          PITCH_Y            = 128,
  parameter int          IND_W              = 10,
  parameter logic [23:0] HL_COLOR           = 24'h0000FF,
  parameter int          BLINK_FRAMES       = 30
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic [CNTR_WIDTH_H-1:0]          CounterX,
  input  logic [CNTR_WIDTH_V-1:0]          CounterY,
  input  logic [GRID_COLS*GRID_ROWS-1:0]   HighlightedProductList,
  input  logic                             SW2,
  output logic [ROM_ADDR_BUS_WIDTH-1:0]    ROM_Addr,
  output logic [3:0]                       ImageID,
  output logic                             isImage,
  output logic                             inHighlightedArea,
  output logic [23:0]                      PixelBus
);

  localparam int N = GRID_COLS * GRID_ROWS;

  // Stage 1 registers
  logic                    hit_q;
  logic [3:0]              k_q;
  logic [CNTR_WIDTH_H-1:0] lx_q;
  logic [CNTR_WIDTH_V-1:0] ly_q;
  logic                    hl_q;

  // Stage 2 (output) registers
  logic [ROM_ADDR_BUS_WIDTH-1:0] rom_addr_q;
  logic [3:0]                    image_id_q;
  logic                          is_image_q;
  logic                          in_hl_q;
  logic [23:0]                   pixel_q;

  // Stage 1 next state
  logic                    hit_d;
  logic [3:0]              k_d;
  logic [CNTR_WIDTH_H-1:0] lx_d;
  logic [CNTR_WIDTH_V-1:0] ly_d;
  logic                    hl_d;

  // Stage 2 next state
  logic [ROM_ADDR_BUS_WIDTH-1:0] rom_addr_d;
  logic                          in_hl_d;
  logic [31:0]                   addr_full;
  logic                          hl_visible;

  logic [31:0] cx;
  logic [31:0] cy;
  logic [15:0] list16;

  assign cx     = 32'(CounterX);
  assign cy     = 32'(CounterY);
  assign list16 = 16'(HighlightedProductList);

  // Cell decode: one range compare per column and per row. The cells never
  // overlap (pitch >= size), so at most one column and one row can match.
  always_comb begin
    int  col_i;
    int  row_i;
    logic col_hit;
    logic row_hit;
    logic basket;
    col_i   = 0;
    row_i   = 0;
    col_hit = 1'b0;
    row_hit = 1'b0;
    basket  = 1'b0;
    lx_d    = '0;
    ly_d    = '0;
    for (int c = 0; c < GRID_COLS; c++) begin
      if (cx >= 32'(X0 + c*PITCH_X) && cx <= 32'(X0 + c*PITCH_X + PIC_W - 1)) begin
        col_hit = 1'b1;
        col_i   = c;
        lx_d    = CounterX - CNTR_WIDTH_H'(X0 + c*PITCH_X);
      end
    end
    for (int r = 0; r < GRID_ROWS; r++) begin
      if (cy >= 32'(Y0 + r*PITCH_Y) && cy <= 32'(Y0 + r*PITCH_Y + PIC_H - 1)) begin
        row_hit = 1'b1;
        row_i   = r;
        ly_d    = CounterY - CNTR_WIDTH_V'(Y0 + r*PITCH_Y);
      end
    end
    hit_d = col_hit & row_hit;
    k_d   = 4'(row_i*GRID_COLS + col_i);
    // Basket strip: one 39-line entry per product, stacked on a 40-line pitch.
    for (int j = 0; j < N; j++) begin
      if (cx >= 32'd20 && cx <= 32'd58 &&
          cy >= 32'(60 + 40*j) && cy <= 32'(98 + 40*j) && list16[j]) begin
        basket = 1'b1;
      end
    end
    hl_d = SW2 ? basket : (hit_d && list16[k_d] && (32'(lx_d) < 32'(IND_W)));
    if (!hit_d) begin
      k_d  = '0;
      lx_d = '0;
      ly_d = '0;
    end
  end

`ifdef HIGHLIGHT_BLINK_EN
  logic [31:0] frame_cnt_q;
  logic        phase_q;
  assign hl_visible = hl_q & phase_q;
`else
  assign hl_visible = hl_q;
`endif

  always_comb begin
    addr_full  = 32'(k_q) * 32'(PIC_W*PIC_H) + 32'(ly_q) * 32'(PIC_W) + 32'(lx_q);
    rom_addr_d = hit_q ? addr_full[ROM_ADDR_BUS_WIDTH-1:0] : '0;
    in_hl_d    = hl_visible;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_q      <= 1'b0;
      k_q        <= '0;
      lx_q       <= '0;
      ly_q       <= '0;
      hl_q       <= 1'b0;
      rom_addr_q <= '0;
      image_id_q <= '0;
      is_image_q <= 1'b0;
      in_hl_q    <= 1'b0;
      pixel_q    <= 24'hFFFFFF;
`ifdef HIGHLIGHT_BLINK_EN
      frame_cnt_q <= '0;
      phase_q     <= 1'b1;
`endif
    end else begin
      hit_q      <= hit_d;
      k_q        <= k_d;
      lx_q       <= lx_d;
      ly_q       <= ly_d;
      hl_q       <= hl_d;
      rom_addr_q <= rom_addr_d;
      image_id_q <= hit_q ? k_q : 4'd0;
      is_image_q <= hit_q;
      in_hl_q    <= in_hl_d;
      pixel_q    <= in_hl_d ? HL_COLOR : 24'hFFFFFF;
`ifdef HIGHLIGHT_BLINK_EN
      if (CounterX == '0 && CounterY == '0) begin
        if (frame_cnt_q == 32'(BLINK_FRAMES - 1)) begin
          frame_cnt_q <= '0;
          phase_q     <= ~phase_q;
        end else begin
          frame_cnt_q <= frame_cnt_q + 32'd1;
        end
      end
`endif
    end
  end

  assign ROM_Addr          = rom_addr_q;
  assign ImageID           = image_id_q;
  assign isImage           = is_image_q;
  assign inHighlightedArea = in_hl_q;
  assign PixelBus          = pixel_q;

endmodule

// File: tb/tb_grid_image_locator.sv
// tb/tb_grid_image_locator.sv - randomized self-checking bench for grid_image_locator
module tb_grid_image_locator;

  localparam int COLS  = 4;
  localparam int ROWS  = 3;
  localparam int N     = COLS * ROWS;
  localparam int PW    = 100;
  localparam int PH    = 100;
  localparam int GX0   = 308;
  localparam int GY0   = 20;
  localparam int PX    = 128;
  localparam int PY    = 128;
  localparam int INDW  = 10;
  localparam int AW    = 17;

  typedef struct packed {
    logic [AW-1:0] rom;
    logic [3:0]    id;
    logic          img;
    logic          hl;
  } exp_t;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [10:0]   CounterX = '0;
  logic [9:0]    CounterY = '0;
  logic [N-1:0]  HighlightedProductList = '0;
  logic          SW2 = 1'b0;
  logic [AW-1:0] ROM_Addr;
  logic [3:0]    ImageID;
  logic          isImage;
  logic          inHighlightedArea;
  logic [23:0]   PixelBus;

  int n_checks = 0;
  int n_pass   = 0;
  exp_t pipe[$];

  grid_image_locator dut (
    .CLK                    (CLK),
    .RST                    (RST),
    .CounterX               (CounterX),
    .CounterY               (CounterY),
    .HighlightedProductList (HighlightedProductList),
    .SW2                    (SW2),
    .ROM_Addr               (ROM_Addr),
    .ImageID                (ImageID),
    .isImage                (isImage),
    .inHighlightedArea      (inHighlightedArea),
    .PixelBus               (PixelBus)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    else
      n_pass++;
  endtask

  // Reference: locate the cell by division/modulo on the pitch grid.
  function automatic exp_t model(int x, int y, logic [N-1:0] list, logic sw2);
    exp_t e;
    int c, r, lx, ly, k, j, off;
    bit hit;
    e   = '0;
    hit = 0;
    k   = 0;
    lx  = 0;
    if (x >= GX0 && y >= GY0) begin
      c   = (x - GX0) / PX;
      lx  = (x - GX0) % PX;
      r   = (y - GY0) / PY;
      ly  = (y - GY0) % PY;
      hit = (c < COLS) && (r < ROWS) && (lx < PW) && (ly < PH);
      if (hit) begin
        k     = r * COLS + c;
        e.img = 1'b1;
        e.id  = 4'(k);
        e.rom = AW'(k * PW * PH + ly * PW + lx);
      end
    end
    if (!sw2) begin
      e.hl = hit && list[k] && (lx < INDW);
    end else if (x >= 20 && x <= 58 && y >= 60) begin
      j   = (y - 60) / 40;
      off = (y - 60) % 40;
      e.hl = (off <= 38) && (j < N) && list[j];
    end
    return e;
  endfunction

  task automatic compare(input exp_t e);
    check("isImage",   32'(isImage),           32'(e.img));
    check("ImageID",   32'(ImageID),           32'(e.id));
    check("ROM_Addr",  32'(ROM_Addr),          32'(e.rom));
    check("inHlArea",  32'(inHighlightedArea), 32'(e.hl));
    check("PixelBus",  32'(PixelBus),          e.hl ? 32'h0000FF : 32'hFFFFFF);
  endtask

  // One clock: drive a pixel, then check the output that left the pipe.
  task automatic cycle(input int x, input int y, input logic [N-1:0] list,
                       input logic sw2, input logic rst);
    @(negedge CLK);
    CounterX = 11'(x);
    CounterY = 10'(y);
    HighlightedProductList = list;
    SW2 = sw2;
    RST = rst;
    @(posedge CLK);
    #1;
    if (rst) begin
      pipe.delete();
      compare('0);
    end else begin
      pipe.push_back(model(x, y, list, sw2));
      if (pipe.size() >= 2) compare(pipe.pop_front());
      else compare('0);
    end
  endtask

  initial begin
    int x, y, sel;
    logic [N-1:0] list;
    logic sw2;

    cycle(0, 0, '0, 1'b0, 1'b1);
    cycle(0, 0, '0, 1'b0, 1'b1);

    // Cell boundaries and interiors
    cycle(308, 20,  '0, 1'b0, 1'b0);
    cycle(407, 20,  '0, 1'b0, 1'b0);
    cycle(408, 20,  '0, 1'b0, 1'b0);
    cycle(307, 20,  '0, 1'b0, 1'b0);
    cycle(308, 19,  '0, 1'b0, 1'b0);
    cycle(308, 119, '0, 1'b0, 1'b0);
    cycle(308, 120, '0, 1'b0, 1'b0);
    cycle(437, 21,  '0, 1'b0, 1'b0);
    cycle(791, 375, '0, 1'b0, 1'b0);
    cycle(792, 375, '0, 1'b0, 1'b0);

    // Image-strip highlight
    cycle(436, 100, 12'h002, 1'b0, 1'b0);
    cycle(445, 100, 12'h002, 1'b0, 1'b0);
    cycle(446, 100, 12'h002, 1'b0, 1'b0);
    cycle(308, 20,  12'h002, 1'b0, 1'b0);

    // Basket-strip highlight
    cycle(30, 520, 12'h800, 1'b1, 1'b0);
    cycle(30, 499, 12'h800, 1'b1, 1'b0);
    cycle(59, 520, 12'h800, 1'b1, 1'b0);
    cycle(20, 538, 12'h800, 1'b1, 1'b0);
    cycle(58, 500, 12'h800, 1'b1, 1'b0);
    cycle(30, 60,  12'h001, 1'b1, 1'b0);

    // Reset pulse while streaming the same pixel
    for (int i = 0; i < 4; i++) cycle(437, 21, 12'h002, 1'b0, 1'b0);
    cycle(437, 21, 12'h002, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(437, 21, 12'h002, 1'b0, 1'b0);

    // Randomized pixels, boundary-biased, with per-pixel mode changes
    for (int i = 0; i < 400; i++) begin
      sel  = int'($urandom_range(0, 3));
      list = N'($urandom);
      sw2  = 1'($urandom);
      if (sel == 0) begin
        x = GX0 + int'($urandom_range(0, COLS - 1)) * PX + int'($urandom_range(0, 3)) - 1;
        if (x >= GX0 + PW && ($urandom & 1) == 1) x = x + PW - 3;
        y = GY0 + int'($urandom_range(0, ROWS - 1)) * PY + int'($urandom_range(0, PH + 1)) - 1;
      end else if (sel == 1) begin
        x = int'($urandom_range(18, 60));
        y = int'($urandom_range(56, 560));
      end else begin
        x = int'($urandom_range(0, 900));
        y = int'($urandom_range(0, 560));
      end
      cycle(x, y, list, sw2, ($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
